// File: rtl/mixer_pkg.sv
// Shared types and helpers for the TDM audio mixer.
//   state_t   : sequencer states (IDLE, ACCUM, DONE)
//   sat       : clamps a signed value to a w-bit signed range
//   gain_step : moves a gain one ramp step toward its target
package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   // Clamp v to [-2**(w-1), 2**(w-1)-1]; w must be between 2 and 63.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                              input int unsigned       w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

   // One step of at most 'step' toward tgt; step 0 jumps straight to tgt.
   function automatic int unsigned gain_step(input int unsigned cur,
                                             input int unsigned tgt,
                                             input int unsigned step);
      int unsigned diff;
      if (step == 0) begin
         return tgt;
      end
      if (tgt >= cur) begin
         diff = tgt - cur;
         return cur + ((diff < step) ? diff : step);
      end
      diff = cur - tgt;
      return cur - ((diff < step) ? diff : step);
   endfunction

endpackage

// File: rtl/mixer_gain_ramp.sv
// Per-channel gain ramp: holds the current gain and advances it one step
// toward the target each time a sample set is accepted.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset, gain returns to 0
//   adv_i    : advance one step (sample accept)
//   target_i : gain to ramp toward
//   gain_o   : current gain
module mixer_gain_ramp
   import mixer_pkg::*;
#(
   parameter int unsigned GAIN_BITS = 8,
   parameter int unsigned RAMP_STEP = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 adv_i,
   input  logic [GAIN_BITS-1:0] target_i,
   output logic [GAIN_BITS-1:0] gain_o
);

   logic [GAIN_BITS-1:0] gain_q;
   logic [GAIN_BITS-1:0] gain_d;

   always_comb begin
      gain_d = gain_q;
      if (adv_i) begin
         gain_d = GAIN_BITS'(gain_step(32'(gain_q), 32'(target_i), RAMP_STEP));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gain_q <= '0;
      end else begin
         gain_q <= gain_d;
      end
   end

   assign gain_o = gain_q;

endmodule

// File: rtl/mixer_tdm.sv
// Multi-channel TDM audio mixer: one shared multiply-accumulate walks the
// channels one per clock, the sum is scaled back by unity gain and saturated.
// Gains ramp toward their targets on every accepted sample set.
//   clk_in / rst_in   : clock, asynchronous active-high reset
//   sample_valid_in   : strobe, accepted only when the sequencer is idle
//   data_in           : signed per-channel samples, latched on accept
//   volume_in/mute_in : per-channel target gain (mute forces 0)
//   busy_out          : accept through result cycle inclusive
//   data_out          : saturated mix, held between valid pulses
//   data_valid_out    : one-cycle result strobe
//   clip_out          : result was saturated
//   overrun_out       : sticky, a strobe arrived while not idle
// Optional MIXER_PEAK_METER_EN adds peak_clr_in / peak_out (max |data_out|).
module mixer_tdm
   import mixer_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned GAIN_BITS = 8,
   parameter int unsigned RAMP_STEP = 4
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                sample_valid_in,
   input  logic [CHANNELS-1:0][WIDTH-1:0]      data_in,
   input  logic [CHANNELS-1:0][GAIN_BITS-1:0]  volume_in,
   input  logic [CHANNELS-1:0]                 mute_in,
`ifdef MIXER_PEAK_METER_EN
   input  logic                                peak_clr_in,
   output logic [WIDTH-1:0]                    peak_out,
`endif
   output logic                                busy_out,
   output logic signed [WIDTH-1:0]             data_out,
   output logic                                data_valid_out,
   output logic                                clip_out,
   output logic                                overrun_out
);

   localparam int unsigned IDX_W  = $clog2(CHANNELS);
   localparam int unsigned PROD_W = WIDTH + GAIN_BITS + 1;
   localparam int unsigned ACC_W  = PROD_W + $clog2(CHANNELS);

   state_t                        state_q;
   logic [IDX_W-1:0]              idx_q;
   logic signed [ACC_W-1:0]       acc_q;
   logic [CHANNELS-1:0][WIDTH-1:0] lat_q;
   logic                          busy_q;
   logic                          valid_q;
   logic                          clip_q;
   logic                          overrun_q;
   logic signed [WIDTH-1:0]       data_q;

   logic                          accept_c;
   logic [GAIN_BITS-1:0]          gain_w [CHANNELS];

   assign accept_c = sample_valid_in && (state_q == IDLE);

   // One ramp per channel; all advance together on accept.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ramp
      logic [GAIN_BITS-1:0] tgt_c;
      assign tgt_c = mute_in[i] ? '0 : volume_in[i];
      mixer_gain_ramp #(
         .GAIN_BITS(GAIN_BITS),
         .RAMP_STEP(RAMP_STEP)
      ) u_ramp (
         .clk_i   (clk_in),
         .rst_i   (rst_in),
         .adv_i   (accept_c),
         .target_i(tgt_c),
         .gain_o  (gain_w[i])
      );
   end

   // Shared multiplier: the gain is zero-extended so it multiplies as positive.
   logic signed [PROD_W-1:0] smp_c;
   logic signed [PROD_W-1:0] gn_c;
   logic signed [PROD_W-1:0] prod_c;

   always_comb begin
      smp_c  = PROD_W'($signed(lat_q[idx_q]));
      gn_c   = PROD_W'($signed({1'b0, gain_w[idx_q]}));
      prod_c = smp_c * gn_c;
   end

   // Scale back by unity gain (floor) and clamp to the output width.
   logic signed [ACC_W-1:0] shr_c;
   logic signed [63:0]      wide_c;
   logic signed [63:0]      sat_c;
   logic                    clip_c;
   logic signed [WIDTH-1:0] out_c;

   always_comb begin
      shr_c  = acc_q >>> (GAIN_BITS - 1);
      wide_c = 64'(shr_c);
      sat_c  = sat(wide_c, WIDTH);
      clip_c = (sat_c != wide_c);
      out_c  = WIDTH'(sat_c);
   end

   // Sequencer, accumulator and registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         lat_q     <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         clip_q    <= 1'b0;
         overrun_q <= 1'b0;
         data_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         clip_q  <= 1'b0;
         busy_q  <= accept_c || (state_q != IDLE);
         if (sample_valid_in && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (sample_valid_in) begin
                  lat_q   <= data_in;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               acc_q <= acc_q + ACC_W'(prod_c);
               if (idx_q == IDX_W'(CHANNELS - 1)) begin
                  idx_q   <= '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            DONE: begin
               data_q  <= out_c;
               clip_q  <= clip_c;
               valid_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_out       = busy_q;
   assign data_out       = data_q;
   assign data_valid_out = valid_q;
   assign clip_out       = clip_q;
   assign overrun_out    = overrun_q;

`ifdef MIXER_PEAK_METER_EN
   // Magnitude of the new result; the most negative code maps to the max positive.
   logic [WIDTH-1:0] mag_c;
   logic [WIDTH-1:0] peak_q;

   always_comb begin
      mag_c = WIDTH'(out_c);
      if (out_c[WIDTH-1]) begin
         if (out_c == {1'b1, {(WIDTH-1){1'b0}}}) begin
            mag_c = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            mag_c = WIDTH'(-out_c);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         peak_q <= '0;
      end else if (peak_clr_in) begin
         peak_q <= '0;
      end else if ((state_q == DONE) && (mag_c > peak_q)) begin
         peak_q <= mag_c;
      end
   end

   assign peak_out = peak_q;
`endif

endmodule

// File: tb/tb_mixer_tdm.sv
// Bench for mixer_tdm: a RAMP_STEP=0 instance for the mixing/saturation table
// and sequencing corners, and a RAMP_STEP=4 instance for gain ramping.
module tb_mixer_tdm;

   localparam int unsigned W = 16;
   localparam int unsigned C = 4;
   localparam int unsigned G = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic                 strobe;
   logic [C-1:0][W-1:0]  din;
   logic [C-1:0][G-1:0]  vol;
   logic [C-1:0]         mute;

   logic                 busy0, dv0, clip0, ovr0;
   logic signed [W-1:0]  dout0;
   logic                 busy4, dv4, clip4, ovr4;
   logic signed [W-1:0]  dout4;
`ifdef MIXER_PEAK_METER_EN
   logic                 peak_clr;
   logic [W-1:0]         peak0, peak4;
`endif

   mixer_tdm #(.WIDTH(W), .CHANNELS(C), .GAIN_BITS(G), .RAMP_STEP(0)) dut0 (
      .clk_in(clk), .rst_in(rst), .sample_valid_in(strobe),
      .data_in(din), .volume_in(vol), .mute_in(mute),
`ifdef MIXER_PEAK_METER_EN
      .peak_clr_in(peak_clr), .peak_out(peak0),
`endif
      .busy_out(busy0), .data_out(dout0), .data_valid_out(dv0),
      .clip_out(clip0), .overrun_out(ovr0)
   );

   mixer_tdm #(.WIDTH(W), .CHANNELS(C), .GAIN_BITS(G), .RAMP_STEP(4)) dut4 (
      .clk_in(clk), .rst_in(rst), .sample_valid_in(strobe),
      .data_in(din), .volume_in(vol), .mute_in(mute),
`ifdef MIXER_PEAK_METER_EN
      .peak_clr_in(peak_clr), .peak_out(peak4),
`endif
      .busy_out(busy4), .data_out(dout4), .data_valid_out(dv4),
      .clip_out(clip4), .overrun_out(ovr4)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      strobe = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Accept one sample set and wait (bounded) for the result pulse.
   task automatic sample(input logic [C-1:0][W-1:0] d, input logic [C-1:0][G-1:0] v,
                         input logic [C-1:0] m, output int lat, output longint r0,
                         output longint c0, output longint r4, output logic bmid,
                         output logic b_after, output logic v_after, output longint hold);
      din = d; vol = v; mute = m; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      bmid = busy0; lat = -1; r0 = 0; c0 = 0; r4 = 0;
      for (int cyc = 1; cyc <= 12 && lat < 0; cyc++) begin
         tick();
         bmid = bmid & busy0;
         if (dv0) begin
            lat = cyc; r0 = dout0; c0 = clip0;
            r4 = dv4 ? longint'(dout4) : -99999;
         end
      end
      tick();
      b_after = busy0; v_after = dv0; hold = dout0;
   endtask

   typedef struct {
      logic [C-1:0][W-1:0] d;
      logic [C-1:0][G-1:0] v;
      logic [C-1:0]        m;
      longint              exp_d;
      longint              exp_c;
   } vec_t;

   function automatic vec_t mk(input longint d0, input longint d1, input longint d2,
                               input longint d3, input int v0, input int v1, input int v2,
                               input int v3, input logic [C-1:0] m, input longint e,
                               input longint c);
      vec_t r;
      r.d[0] = W'(d0); r.d[1] = W'(d1); r.d[2] = W'(d2); r.d[3] = W'(d3);
      r.v[0] = G'(v0); r.v[1] = G'(v1); r.v[2] = G'(v2); r.v[3] = G'(v3);
      r.m = m; r.exp_d = e; r.exp_c = c;
      return r;
   endfunction

   vec_t vecs[12];

   initial begin
      int      lat;
      longint  r0, c0, r4, hold;
      logic    bmid, b_after, v_after;
      int      g;
      int      nvalid;
      logic [C-1:0][W-1:0] d;
      logic [C-1:0][G-1:0] v;

      rst = 1'b1; strobe = 1'b0; din = '0; vol = '0; mute = '0;
`ifdef MIXER_PEAK_METER_EN
      peak_clr = 1'b0;
`endif

      vecs[0]  = mk(1000, 2000, -500, 0, 128, 128, 128, 128, 4'b0000, 2500, 0);
      vecs[1]  = mk(30000, 30000, 30000, 30000, 255, 255, 255, 255, 4'b0000, 32767, 1);
      vecs[2]  = mk(-30000, -30000, -30000, -30000, 255, 255, 255, 255, 4'b0000, -32768, 1);
      vecs[3]  = mk(100, 100, 100, 100, 128, 128, 128, 128, 4'b0010, 300, 0);
      vecs[4]  = mk(-3, 0, 0, 0, 1, 0, 0, 0, 4'b0000, -1, 0);
      vecs[5]  = mk(32767, 0, 0, 0, 128, 128, 128, 128, 4'b0000, 32767, 0);
      vecs[6]  = mk(-32768, 0, 0, 0, 128, 128, 128, 128, 4'b0000, -32768, 0);
      vecs[7]  = mk(16384, 16384, 0, 0, 128, 128, 128, 128, 4'b0000, 32767, 1);
      vecs[8]  = mk(1001, 1001, 1001, 1001, 64, 64, 64, 64, 4'b0000, 2002, 0);
      vecs[9]  = mk(1000, 1000, 1000, 1000, 255, 128, 64, 0, 4'b0000, 3492, 0);
      vecs[10] = mk(5000, 5000, 5000, 5000, 200, 200, 200, 200, 4'b1111, 0, 0);
      vecs[11] = mk(-16384, -16384, -1, 0, 128, 128, 128, 128, 4'b0000, -32768, 1);

      // Reset state
      tick(); tick();
      chk("rst_data_out", dout0, 0);
      chk("rst_valid", dv0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_clip", clip0, 0);
      chk("rst_overrun", ovr0, 0);
      chk("rst_busy_r4", busy4, 0);
      rst = 1'b0;
      tick();

      // Mixing / saturation table
      for (int i = 0; i < 12; i++) begin
         sample(vecs[i].d, vecs[i].v, vecs[i].m, lat, r0, c0, r4, bmid, b_after, v_after, hold);
         chk($sformatf("v%0d_latency", i), lat, 5);
         chk($sformatf("v%0d_data", i), r0, vecs[i].exp_d);
         chk($sformatf("v%0d_clip", i), c0, vecs[i].exp_c);
         chk($sformatf("v%0d_busy_0to5", i), bmid, 1);
         chk($sformatf("v%0d_busy_after", i), b_after, 0);
         chk($sformatf("v%0d_valid_pulse", i), v_after, 0);
         chk($sformatf("v%0d_hold", i), hold, vecs[i].exp_d);
      end
      chk("overrun_clean", ovr0, 0);

      // Strobe during ACCUM: ignored, overrun set and sticky
      din = vecs[0].d; vol = vecs[0].v; mute = '0; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
      strobe = 1'b1;
      for (int i = 0; i < C; i++) begin
         din[i] = W'(9999); vol[i] = G'(255);
      end
      tick();
      strobe = 1'b0;
      chk("overrun_set", ovr0, 1);
      lat = -1;
      for (int cyc = 3; cyc <= 12 && lat < 0; cyc++) begin
         tick();
         if (dv0) begin lat = cyc; r0 = dout0; end
      end
      chk("ovr_latency", lat, 5);
      chk("ovr_data", r0, 2500);
      tick();
      sample(vecs[3].d, vecs[3].v, 4'b0000, lat, r0, c0, r4, bmid, b_after, v_after, hold);
      chk("after_ovr_data", r0, 400);
      chk("overrun_sticky", ovr0, 1);

      // Strobe on the DONE edge is ignored; the next edge is the first accept
      din = vecs[0].d; vol = vecs[0].v; mute = '0; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick(); tick(); tick(); tick();
      strobe = 1'b1;
      for (int i = 0; i < C; i++) din[i] = W'(100);
      tick();
      chk("b2b_first_valid", dv0, 1);
      chk("b2b_first_data", dout0, 2500);
      tick();
      strobe = 1'b0;
      chk("b2b_busy", busy0, 1);
      lat = -1;
      for (int cyc = 1; cyc <= 10 && lat < 0; cyc++) begin
         tick();
         if (dv0) begin lat = cyc; r0 = dout0; end
      end
      chk("b2b_second_latency", lat, 5);
      chk("b2b_second_data", r0, 400);
      tick();

      // Reset in the middle of ACCUM
      din = vecs[8].d; vol = vecs[8].v; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick(); tick();
      #1 rst = 1'b1;
      #1;
      chk("midrst_data", dout0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_overrun", ovr0, 0);
      chk("midrst_valid", dv0, 0);
      tick();
      rst = 1'b0;
      nvalid = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         if (dv0) nvalid++;
      end
      chk("midrst_no_valid", nvalid, 0);

      // Gain ramp up then down (RAMP_STEP=4 instance)
      do_reset();
      d = '0; d[0] = W'(1000);
      v = '0; v[0] = G'(128);
      for (int n = 1; n <= 34; n++) begin
         sample(d, v, 4'b1110, lat, r0, c0, r4, bmid, b_after, v_after, hold);
         g = (4 * n > 128) ? 128 : 4 * n;
         chk($sformatf("ramp_up_%0d", n), r4, (longint'(1000) * g) >>> 7);
      end
      chk("ramp_overrun4", ovr4, 0);
      for (int n = 1; n <= 33; n++) begin
         sample(d, v, 4'b1111, lat, r0, c0, r4, bmid, b_after, v_after, hold);
         g = 128 - 4 * n;
         if (g < 0) g = 0;
         chk($sformatf("ramp_down_%0d", n), r4, (longint'(1000) * g) >>> 7);
      end
      chk("ramp_clip4", clip4, 0);

`ifdef MIXER_PEAK_METER_EN
      // Peak meter
      do_reset();
      chk("peak_rst", peak0, 0);
      d = '0; d[0] = W'(-1200);
      v = '0; v[0] = G'(128);
      sample(d, v, 4'b0000, lat, r0, c0, r4, bmid, b_after, v_after, hold);
      chk("peak_neg", peak0, 1200);
      d[0] = W'(800);
      sample(d, v, 4'b0000, lat, r0, c0, r4, bmid, b_after, v_after, hold);
      chk("peak_keep", peak0, 1200);
      d[0] = W'(-32768);
      sample(d, v, 4'b0000, lat, r0, c0, r4, bmid, b_after, v_after, hold);
      chk("peak_minneg", peak0, 32767);
      din = d; vol = v; mute = '0; strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick(); tick(); tick(); tick();
      peak_clr = 1'b1;
      tick();
      peak_clr = 1'b0;
      chk("peak_clr_valid", dv0, 1);
      chk("peak_clr", peak0, 0);
      tick();
      d[0] = W'(800);
      sample(d, v, 4'b0000, lat, r0, c0, r4, bmid, b_after, v_after, hold);
      chk("peak_after_clr", peak0, 800);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
